// File: rtl/fir_sym_mac_mc.sv
// fir_sym_mac_mc
//   Multi-channel symmetric FIR low-pass filter. All channels share one
//   time-multiplexed pre-adder, multiplier and accumulator. Each channel has
//   its own delay line. The NUM_TAPS/2 unique coefficients can be written at
//   runtime, and reset restores the default low-pass table.
//
// Ports
//   CLK_Filter  filter clock; all logic runs on its rising edge
//   rst         asynchronous active-high reset
//   in_valid    one-cycle strobe that presents a new sample
//   in_ch       channel index of the sample
//   in_data     unsigned sample value
//   coef_we     coefficient write strobe
//   coef_addr   coefficient index k
//   coef_wdata  coefficient value
//   busy        high while a MAC run is in progress
//   out_valid   one-cycle strobe; a filtered result is ready
//   out_ch      channel of the result
//   out_data    filtered result, saturated to OUT_W bits; held until the next result
//   drop_flag   sticky; set when a sample or coefficient write is rejected
//   sat_flag    sticky; set when a result saturates
module fir_sym_mac_mc #(
  parameter int NUM_CH   = 2,
  parameter int NUM_TAPS = 22,
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int OUT_W    = 20,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NH      = NUM_TAPS / 2,
  localparam int K_W     = (NH > 1) ? $clog2(NH) : 1
) (
  input  logic              CLK_Filter,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              coef_we,
  input  logic [K_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              busy,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [OUT_W-1:0]  out_data,
  output logic              drop_flag,
  output logic              sat_flag
);

  localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;
  // The accumulator is wide enough for NH full-scale products, so it never wraps.
  localparam int ACC_W  = PROD_W + K_W;
  localparam int EXT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default coefficients: 10 Hz low-pass at fs = 500 Hz. Any k beyond the table is 0.
  function automatic logic [COEF_W-1:0] default_coef(input int k);
    logic [COEF_W-1:0] c;
    case (k)
      32'd0:   c = COEF_W'(8'd2);
      32'd1:   c = COEF_W'(8'd10);
      32'd2:   c = COEF_W'(8'd16);
      32'd3:   c = COEF_W'(8'd28);
      32'd4:   c = COEF_W'(8'd43);
      32'd5:   c = COEF_W'(8'd60);
      32'd6:   c = COEF_W'(8'd78);
      32'd7:   c = COEF_W'(8'd95);
      32'd8:   c = COEF_W'(8'd111);
      32'd9:   c = COEF_W'(8'd122);
      32'd10:  c = COEF_W'(8'd128);
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   x_r [NUM_CH][NUM_TAPS];
  logic [COEF_W-1:0]   coef_r [NH];
  logic [CH_W-1:0]     ch_r;
  logic [K_W-1:0]      k_r;
  logic [ACC_W-1:0]    acc_r;
  logic                busy_r, out_valid_r, drop_r, sat_r;
  logic [CH_W-1:0]     out_ch_r;
  logic [OUT_W-1:0]    out_data_r;

  logic                ch_ok_s, addr_ok_s, in_idle_s, accept_s, coef_ok_s, drop_s, last_s;
  logic [TAP_W-1:0]    k_tap_s, mir_tap_s;
  logic [PRE_W-1:0]    pre_s;
  logic [PROD_W-1:0]   prod_s;
  logic [ACC_W-1:0]    acc_sum_s;
  logic [EXT_W-1:0]    acc_ext_s;
  logic                sat_s;
  logic [OUT_W-1:0]    res_s;

  assign ch_ok_s   = (32'(in_ch) < 32'(NUM_CH));
  assign addr_ok_s = (32'(coef_addr) < 32'(NH));
  assign in_idle_s = (state_r == ST_IDLE);
  assign accept_s  = in_idle_s & in_valid & ch_ok_s;
  // A sample in the same cycle always wins over a coefficient write.
  assign coef_ok_s = in_idle_s & coef_we & ~in_valid & addr_ok_s;
  assign drop_s    = (in_valid & ~accept_s) | (coef_we & ~coef_ok_s);
  assign last_s    = (state_r == ST_MAC) && (k_r == K_W'(NH - 1));

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_data  = out_data_r;
  assign drop_flag = drop_r;
  assign sat_flag  = sat_r;

  // Next-state logic for the IDLE -> MAC -> DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_MAC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MAC;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Shared datapath: pre-add the mirrored tap pair, multiply, accumulate and saturate.
  always_comb begin
    k_tap_s   = TAP_W'(k_r);
    mir_tap_s = TAP_W'(NUM_TAPS - 1) - k_tap_s;
    pre_s     = {1'b0, x_r[ch_r][k_tap_s]} + {1'b0, x_r[ch_r][mir_tap_s]};
    prod_s    = PROD_W'(coef_r[k_r]) * PROD_W'(pre_s);
    acc_sum_s = acc_r + ACC_W'(prod_s);
    acc_ext_s = EXT_W'(acc_sum_s);
    sat_s     = |acc_ext_s[EXT_W-1:OUT_W];
    if (sat_s) begin
      res_s = '1;
    end else begin
      res_s = acc_ext_s[OUT_W-1:0];
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run control, accumulator, registered outputs and sticky flags.
  // The result is registered on the last MAC step, so it is visible during the DONE cycle.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      ch_r        <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_data_r  <= '0;
      drop_r      <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (drop_s) begin
        drop_r <= 1'b1;
      end
      if (accept_s) begin
        ch_r   <= in_ch;
        k_r    <= '0;
        acc_r  <= '0;
        busy_r <= 1'b1;
      end else if (state_r == ST_MAC) begin
        acc_r <= acc_sum_s;
        k_r   <= k_r + K_W'(1'b1);
        if (last_s) begin
          busy_r      <= 1'b0;
          out_valid_r <= 1'b1;
          out_ch_r    <= ch_r;
          out_data_r  <= res_s;
          if (sat_s) begin
            sat_r <= 1'b1;
          end
        end
      end
    end
  end

  // Per-channel delay lines. Only the addressed channel shifts, and only on an accepted sample.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
          x_r[c][t] <= '0;
        end
      end
    end else if (accept_s) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (in_ch == CH_W'(c)) begin
          for (int t = NUM_TAPS - 1; t > 0; t--) begin
            x_r[c][t] <= x_r[c][t-1];
          end
          x_r[c][0] <= in_data;
        end
      end
    end
  end

  // Coefficient table. It is written only in IDLE, so a run never sees a coefficient change.
  always_ff @(posedge CLK_Filter or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NH; k++) begin
        coef_r[k] <= default_coef(k);
      end
    end else if (coef_ok_s) begin
      coef_r[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_fir_sym_mac_mc.sv
// Testbench for fir_sym_mac_mc with the default parameters (2 channels, 22 taps).
// The reference model is a direct-form convolution: it computes sum(h[i] * x[i])
// over the full symmetric 22-tap response, using per-channel sample histories.
module tb_fir_sym_mac_mc;

  localparam int TAPS = 22;
  localparam int NH   = 11;
  localparam int MAXO = 1048575;

  logic        CLK_Filter;
  logic        rst;
  logic        in_valid;
  logic [0:0]  in_ch;
  logic [7:0]  in_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_wdata;
  logic        busy;
  logic        out_valid;
  logic [0:0]  out_ch;
  logic [19:0] out_data;
  logic        drop_flag;
  logic        sat_flag;

  fir_sym_mac_mc dut (
    .CLK_Filter (CLK_Filter),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ch      (in_ch),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .drop_flag  (drop_flag),
    .sat_flag   (sat_flag)
  );

  initial CLK_Filter = 1'b0;
  always #5 CLK_Filter = ~CLK_Filter;

  int checks = 0;
  int errors = 0;
  int hist [2][TAPS];
  int coef_m [NH];
  int def_c [NH] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
  bit drop_m, sat_m;
  int last_out;

  task automatic tick();
    @(posedge CLK_Filter);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
    for (int k = 0; k < NH; k++) coef_m[k] = def_c[k];
    drop_m = 1'b0;
    sat_m  = 1'b0;
  endfunction

  // Full symmetric response: h[i] = c[i] for i < NH, and h[i] = c[TAPS-1-i] otherwise.
  function automatic int model_out(input int ch);
    int s = 0;
    for (int i = 0; i < TAPS; i++)
      s += coef_m[(i < NH) ? i : TAPS - 1 - i] * hist[ch][i];
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic wcoef(input int addr, input int data);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_wdata = 8'(data);
    tick();
    coef_we = 1'b0;
    if (addr < NH) coef_m[addr] = data;
    else drop_m = 1'b1;
  endtask

  // Sends one sample from IDLE and waits for its result. A non-zero vi_m drives a
  // second in_valid m cycles later. A cw_m >= 0 drives a coef write (k=0) m cycles
  // later; 0 means in the same cycle as the sample. Both must be rejected.
  task automatic feed(input int ch, input int data, input int vi_m, input int cw_m);
    int exp_v, m;
    for (int i = TAPS - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = data;
    exp_v = model_out(ch);
    if (exp_v > MAXO) begin exp_v = MAXO; sat_m = 1'b1; end
    if (vi_m >= 1 && vi_m <= 11) drop_m = 1'b1;
    if (cw_m >= 0 && cw_m <= 11) drop_m = 1'b1;
    in_valid = 1'b1; in_ch = 1'(ch); in_data = 8'(data);
    if (cw_m == 0) begin coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'($urandom_range(0, 255)); end
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    check("busy_rise", busy, 1);
    m = 1;
    while (!out_valid && m < 20) begin
      if (m == vi_m) begin
        in_valid = 1'b1; in_ch = 1'($urandom_range(0, 1)); in_data = 8'($urandom_range(0, 255));
      end
      if (m == cw_m) begin
        coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 8'($urandom_range(0, 255));
      end
      tick();
      m++;
      in_valid = 1'b0; coef_we = 1'b0;
    end
    check("latency", m, 12);
    check("out_valid", out_valid, 1);
    check("out_ch", out_ch, ch);
    check("out_data", out_data, exp_v);
    check("busy_done", busy, 0);
    last_out = out_data;
    tick();
    check("out_valid_pulse", out_valid, 0);
    check("drop_flag", drop_flag, drop_m);
    check("sat_flag", sat_flag, sat_m);
  endtask

  initial begin
    bit ov_seen;
    rst = 1'b1; in_valid = 1'b0; in_ch = 1'b0; in_data = 8'd0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_wdata = 8'd0;
    model_reset();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop", drop_flag, 0);
    check("rst_sat", sat_flag, 0);
    rst = 1'b0;
    tick();

    // Impulse response on IR.
    for (int n = 0; n < 22; n++) begin
      feed(0, (n == 0) ? 100 : 0, 0, -1);
      if (n == 0)  check("impulse_first", last_out, 200);
      if (n == 10) check("impulse_peak", last_out, 12800);
      if (n == 21) check("impulse_last", last_out, 200);
    end

    // Red at full scale, interleaved with IR zeros.
    for (int n = 0; n < 30; n++) begin
      feed(1, 255, 0, -1);
      if (n >= 21) check("red_settled", last_out, 353430);
      feed(0, 0, 0, -1);
      check("ir_zero", last_out, 0);
    end

    // A sample 3 cycles into a run is dropped; the next result is unaffected.
    feed(0, 37, 3, -1);
    feed(1, 200, 0, -1);
    // A coefficient write during a run is ignored.
    feed(0, 90, 0, 5);
    feed(0, 10, 0, -1);

    // A sample and a coefficient write in the same IDLE cycle: the sample wins.
    do_reset();
    check("drop_cleared", drop_flag, 0);
    feed(0, 100, 0, 0);
    check("coef_rejected", last_out, 200);

    // A coefficient write to an out-of-range address is rejected.
    do_reset();
    wcoef(13, 77);
    tick();
    check("bad_addr_drop", drop_flag, 1);
    feed(0, 100, 0, -1);
    check("bad_addr_no_effect", last_out, 200);

    // coef[10] = 255 with DC 255 on IR.
    do_reset();
    wcoef(10, 255);
    for (int n = 0; n < 22; n++) feed(0, 255, 0, -1);
    check("dc_coef10", last_out, 418200);

    // All coefficients at 255 with DC 255 saturates the output.
    for (int k = 0; k < NH; k++) wcoef(k, 255);
    for (int n = 0; n < 3; n++) feed(0, 255, 0, -1);
    check("sat_value", last_out, MAXO);
    check("sat_set", sat_flag, 1);

    // Reset asserted at MAC step 5 produces no result and restores the defaults.
    in_valid = 1'b1; in_ch = 1'b0; in_data = 8'd77;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_drop", drop_flag, 0);
    check("midrst_sat", sat_flag, 0);
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    ov_seen = 1'b0;
    repeat (15) begin
      tick();
      if (out_valid) ov_seen = 1'b1;
    end
    check("midrst_no_out", ov_seen, 0);
    feed(0, 100, 0, -1);
    check("midrst_impulse", last_out, 200);

    // Randomized traffic: both channels, coefficient updates and rejected strobes.
    for (int n = 0; n < 50; n++) begin
      if ($urandom_range(0, 3) == 0) wcoef($urandom_range(0, 10), $urandom_range(0, 255));
      feed($urandom_range(0, 1), $urandom_range(0, 255),
           ($urandom_range(0, 5) == 0) ? $urandom_range(1, 11) : 0,
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, 11) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
